ram_arbiter: RTL and testbench
==============================

# ram_arbiter

Shares the single-port 8-bit level/score RAM between four requesters: the per-user level controller, the display reader, the clear/init engine and the debug port. Requests are granted round-robin, one transaction at a time. The block drives the RAM address, write data and `r_w` strobe, and returns read data plus a one-cycle acknowledge to the winner. It sits between the game-logic controllers and the RAM primitive, replacing their direct RAM connections.

## Interface
- `NREQ`, 4: number of requesters. Fixed at 4; the grant index is 2 bits.
- `ADDR_W`, 8: RAM address width.
- `DATA_W`, 8: RAM data width.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-low reset. One clock domain; the reset is synchronous and active-low.
- `req`  in  NREQ  per-requester transaction request, level, held until `ack`.
- `we`  in  NREQ  per-requester write enable (1 = write, 0 = read), valid while `req`.
- `addr`  in  NREQ*ADDR_W  packed addresses; requester i uses bits [i*8 +: 8].
- `wdata`  in  NREQ*DATA_W  packed write data, same packing.
- `ack`  out  NREQ  one-cycle completion pulse, one-hot.
- `rdata`  out  DATA_W  read result, valid in the `ack` cycle and held until the next read completes.
- `busy`  out  1  high while a transaction is in flight (state ≠ IDLE).
- `grant_id`  out  2  index of the current or most recent grantee.
- `ram_addr`  out  ADDR_W  RAM address.
- `ram_wdata`  out  DATA_W  RAM write data.
- `ram_r_w`  out  1  RAM strobe, 1 = write, 0 = read.
- `ram_rdata`  in  DATA_W  RAM read data. The RAM is synchronous and its registered output is valid one cycle after the address is sampled.

## Operation
- **FSM states:** IDLE, ACCESS, RDWAIT.
- **IDLE:** the eligible set is `req` with any requester whose `ack` is high this cycle masked out. If the set is non-empty, pick the first eligible requester g, searching from `last_grant+1` modulo 4. At the clock edge:
  - latch `ram_addr` ← `addr[g]`, `ram_wdata` ← `wdata[g]`, `ram_r_w` ← `we[g]`;
  - set `grant_id`/`last_grant` ← g;
  - go to ACCESS.
- **ACCESS** (the RAM samples at the end of this cycle):
  - Write: `ram_r_w` ← 0, `ack[g]` ← 1, go to IDLE.
  - Read: `ram_r_w` stays 0, go to RDWAIT.
- **RDWAIT:** `rdata` ← `ram_rdata`, `ack[g]` ← 1, go to IDLE.
- **Round-robin:** after reset `last_grant` = 3, so requester 0 has first priority. A granted requester drops to lowest priority.
- **Input latching:** the address, data and direction are latched at grant. Input changes after grant are ignored.
- **`req` dropped before `ack`:** protocol violation. The transaction still completes and `ack` still pulses.
- **`req` held high through the `ack` cycle:** the requester is masked in that cycle. If `req` is still high in the following cycle, it is a new request.
- **Reset while a transaction is in flight:** the transaction is abandoned and no `ack` is issued. A write whose ACCESS cycle coincides with the reset edge may still land in the RAM; this is accepted.
- **Reset values:** state = IDLE; `ack` = 0, `rdata` = 0, `busy` = 0, `grant_id` = 0, `ram_addr` = 0, `ram_wdata` = 0, `ram_r_w` = 0; `last_grant` = 3.

## Timing
- Write: `req` seen in IDLE at cycle 0 → `ram_r_w` = 1 in cycle 1 → `ack` in cycle 2. The next grant is possible from cycle 2 onward.
- Read: `req` at cycle 0 → address on the RAM in cycle 1 → `ram_rdata` valid in cycle 2 → `rdata` and `ack` in cycle 3.
- Throughput: one write every 2 cycles, one read every 3 cycles.
- `ram_r_w` is high for exactly one cycle per write and is never high in IDLE or RDWAIT.
- `ack` is a single-cycle pulse and at most one bit is set.

## Structure
- Shared package `ram_pkg`: `ADDR_W`, `DATA_W`, `NREQ`, `RW_WRITE` = 1 / `RW_READ` = 0, and the `arb_state_t` enum (IDLE, ACCESS, RDWAIT).
- One sub-module, `rr_picker`: a combinational 4-way rotating-priority encoder. Inputs are the eligible mask and `last_grant`; outputs are `valid` and `idx[1:0]`.
- The FSM, latches and output registers live in `ram_arbiter`.

## Test plan
- **Reset:** hold `reset` = 0 for 3 cycles while driving `req` = 4'b1111 → all outputs zero, no `ack`; after release, the first grant goes to requester 0.
- **Single write then read:** requester 2 writes 0x2A to address 0x03, then reads address 0x03 → `ack[2]` in cycle 2, `ram_r_w` = 1 only in cycle 1; `rdata` = 0x2A with `ack[2]` in cycle 3 of the read.
- **Round-robin fairness:** `req` = 4'b1111 held continuously, all writes → grant order 0, 1, 2, 3, 0, …, one `ack` every 2 cycles.
- **Masking in the ack cycle:** only requester 1 requests, with `req` held high through its `ack` → no back-to-back duplicate grant in the `ack` cycle; the next grant to 1 comes one cycle after the `ack`.
- **Mid-operation reset:** assert reset while in RDWAIT for requester 3 → no `ack[3]`, `rdata` = 0; after release, requester 0 has priority.
- **Input change after grant:** requester 0 issues a read of address 0x01, then changes `addr` to 0x02 in the ACCESS cycle → `ram_addr` stays 0x01 and `rdata` = mem[0x01].

Source files
------------

// File: rtl/ram_pkg.sv
// Shared constants and types for the level/score RAM arbiter.
package ram_pkg;

  localparam int NREQ   = 4;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

  localparam logic RW_WRITE = 1'b1;
  localparam logic RW_READ  = 1'b0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RDWAIT = 2'd2
  } arb_state_t;

  // One-hot acknowledge vector for a grant index.
  function automatic logic [NREQ-1:0] grant_onehot(input logic [1:0] idx);
    return {{(NREQ-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// Requester bus plus RAM primitive connection for ram_arbiter.
interface ram_arbiter_if;
  import ram_pkg::*;

  logic [NREQ-1:0]        req;
  logic [NREQ-1:0]        we;
  logic [NREQ*ADDR_W-1:0] addr;
  logic [NREQ*DATA_W-1:0] wdata;
  logic [NREQ-1:0]        ack;
  logic [DATA_W-1:0]      rdata;
  logic                   busy;
  logic [1:0]             grant_id;
  logic [ADDR_W-1:0]      ram_addr;
  logic [DATA_W-1:0]      ram_wdata;
  logic                   ram_r_w;
  logic [DATA_W-1:0]      ram_rdata;

  // Requesters and the RAM primitive together form the master side.
  modport master (
    output req, we, addr, wdata, ram_rdata,
    input  ack, rdata, busy, grant_id, ram_addr, ram_wdata, ram_r_w
  );

  modport slave (
    input  req, we, addr, wdata, ram_rdata,
    output ack, rdata, busy, grant_id, ram_addr, ram_wdata, ram_r_w
  );

endinterface

// File: rtl/ram_arbiter_rr_picker.sv
// Combinational 4-way rotating-priority encoder; the slot after i_last_grant
// has highest priority and i_last_grant itself has lowest.
module rr_picker
  import ram_pkg::*;
(
  input  logic [NREQ-1:0] i_mask,
  input  logic [1:0]      i_last_grant,
  output logic            o_valid,
  output logic [1:0]      o_idx
);

  logic [1:0] w_cand;

  // Scan from farthest to nearest so the nearest eligible slot wins.
  always_comb begin
    o_valid = |i_mask;
    o_idx   = i_last_grant;
    w_cand  = i_last_grant;
    for (int k = NREQ; k >= 1; k--) begin
      w_cand = i_last_grant + 2'(k);
      if (i_mask[w_cand]) begin
        o_idx = w_cand;
      end else begin
        o_idx = o_idx;
      end
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one synchronous single-port RAM between four
// requesters, one transaction at a time.
module ram_arbiter
  import ram_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  ram_arbiter_if.slave  bus
);

  arb_state_t        r_state;
  logic [1:0]        r_last_grant;
  logic [1:0]        r_grant_id;
  logic [NREQ-1:0]   r_ack;
  logic [DATA_W-1:0] r_rdata;
  logic              r_busy;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [DATA_W-1:0] r_ram_wdata;
  logic              r_ram_r_w;
  logic              r_is_write;

  logic [NREQ-1:0]   w_eligible;
  logic              w_valid;
  logic [1:0]        w_idx;

  // A requester acknowledged this cycle is not eligible again until next cycle.
  assign w_eligible = bus.req & ~r_ack;

  rr_picker u_picker (
    .i_mask       (w_eligible),
    .i_last_grant (r_last_grant),
    .o_valid      (w_valid),
    .o_idx        (w_idx)
  );

  // Arbitration FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_last_grant <= 2'd3;
      r_grant_id   <= 2'd0;
      r_ack        <= {NREQ{1'b0}};
      r_rdata      <= {DATA_W{1'b0}};
      r_busy       <= 1'b0;
      r_ram_addr   <= {ADDR_W{1'b0}};
      r_ram_wdata  <= {DATA_W{1'b0}};
      r_ram_r_w    <= RW_READ;
      r_is_write   <= 1'b0;
    end else begin
      r_ack <= {NREQ{1'b0}};
      case (r_state)
        IDLE: begin
          if (w_valid) begin
            r_ram_addr   <= bus.addr[int'(w_idx)*ADDR_W +: ADDR_W];
            r_ram_wdata  <= bus.wdata[int'(w_idx)*DATA_W +: DATA_W];
            r_ram_r_w    <= bus.we[w_idx] ? RW_WRITE : RW_READ;
            r_is_write   <= bus.we[w_idx];
            r_grant_id   <= w_idx;
            r_last_grant <= w_idx;
            r_busy       <= 1'b1;
            r_state      <= ACCESS;
          end else begin
            r_state <= IDLE;
          end
        end
        ACCESS: begin
          r_ram_r_w <= RW_READ;
          if (r_is_write) begin
            r_ack   <= grant_onehot(r_grant_id);
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_state <= RDWAIT;
          end
        end
        RDWAIT: begin
          r_rdata <= bus.ram_rdata;
          r_ack   <= grant_onehot(r_grant_id);
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_ram_r_w <= RW_READ;
          r_busy    <= 1'b0;
          r_state   <= IDLE;
        end
      endcase
    end
  end

  assign bus.ack       = r_ack;
  assign bus.rdata     = r_rdata;
  assign bus.busy      = r_busy;
  assign bus.grant_id  = r_grant_id;
  assign bus.ram_addr  = r_ram_addr;
  assign bus.ram_wdata = r_ram_wdata;
  assign bus.ram_r_w   = r_ram_r_w;

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter with a behavioural synchronous RAM.
module tb_ram_arbiter;

  typedef struct {
    logic [3:0] ack_oh;
    logic       wr;
    logic [7:0] data;
  } exp_t;

  logic clk;
  logic reset;
  ram_arbiter_if bus ();

  ram_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  logic [7:0] mem    [256];
  logic [7:0] shadow [256];
  exp_t       sb[$];
  int         n_total = 0;
  int         n_bad   = 0;
  bit         hold_req = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous RAM: registered read output, write on strobe.
  always @(posedge clk) begin
    if (bus.ram_r_w) mem[bus.ram_addr] <= bus.ram_wdata;
    bus.ram_rdata <= mem[bus.ram_addr];
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input int id, input bit wr, input logic [7:0] a, input logic [7:0] d);
    exp_t e;
    if (wr) shadow[a] = d;
    e.ack_oh = 4'b0001 << id;
    e.wr     = wr;
    e.data   = wr ? d : shadow[a];
    sb.push_back(e);
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (bus.ack != 4'b0000) begin
      if (sb.size() == 0) begin
        chk("unexpected_ack", 32'(bus.ack), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("ack_id", 32'(bus.ack), 32'(e.ack_oh));
        if (!e.wr) chk("rdata", 32'(bus.rdata), 32'(e.data));
      end
      if (!hold_req) bus.req = bus.req & ~bus.ack;
    end
  endtask

  task automatic set_req(input int i, input bit wr, input logic [7:0] a, input logic [7:0] d);
    bus.addr[i*8 +: 8]  = a;
    bus.wdata[i*8 +: 8] = d;
    bus.we[i]           = wr;
    bus.req[i]          = 1'b1;
  endtask

  task automatic do_txn(input int i, input bit wr, input logic [7:0] a, input logic [7:0] d,
                        output int lat, output logic [7:0] rw_trace, output logic [7:0] addr1);
    bit got;
    got = 1'b0;
    lat = 0;
    rw_trace = 8'h00;
    addr1 = 8'h00;
    push_exp(i, wr, a, d);
    set_req(i, wr, a, d);
    while (!got && lat < 7) begin
      tick();
      lat++;
      rw_trace[lat] = bus.ram_r_w;
      if (lat == 1) addr1 = bus.ram_addr;
      if (bus.ack[i]) got = 1'b1;
    end
    if (!got) chk("txn_timeout", 32'd0, 32'd1);
    bus.req[i] = 1'b0;
    tick();
  endtask

  initial begin
    int         lat;
    int         n_ack;
    int         n_rw;
    int         last_ack;
    int         bound;
    logic [7:0] rw_trace;
    logic [7:0] addr1;

    for (int k = 0; k < 256; k++) begin
      mem[k]    = 8'h00;
      shadow[k] = 8'h00;
    end
    reset     = 1'b0;
    bus.req   = 4'hF;
    bus.we    = 4'hF;
    bus.addr  = {8'h13, 8'h12, 8'h11, 8'h10};
    bus.wdata = {8'hA3, 8'hA2, 8'hA1, 8'hA0};

    // Reset held with all requests asserted.
    repeat (3) tick();
    chk("rst_ack", 32'(bus.ack), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_grant_id", 32'(bus.grant_id), 32'd0);
    chk("rst_ram_addr", 32'(bus.ram_addr), 32'd0);
    chk("rst_ram_wdata", 32'(bus.ram_wdata), 32'd0);
    chk("rst_ram_r_w", 32'(bus.ram_r_w), 32'd0);
    chk("rst_rdata", 32'(bus.rdata), 32'd0);

    // Release: continuous writes from all four, round-robin order.
    hold_req = 1'b1;
    reset = 1'b1;
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < 4; i++) push_exp(i, 1'b1, 8'(8'h10 + i), 8'(8'hA0 + i));
    tick();
    chk("first_grant", 32'(bus.grant_id), 32'd0);
    chk("first_rw", 32'(bus.ram_r_w), 32'd1);
    chk("first_addr", 32'(bus.ram_addr), 32'h10);
    chk("first_busy", 32'(bus.busy), 32'd1);
    n_ack = 0;
    n_rw = 1;
    last_ack = 0;
    for (int c = 2; c <= 16; c++) begin
      tick();
      if (bus.ram_r_w) n_rw++;
      if (bus.ack != 4'b0000) begin
        n_ack++;
        if (last_ack != 0) chk("ack_spacing", 32'(c - last_ack), 32'd2);
        last_ack = c;
      end
    end
    bus.req = 4'h0;
    hold_req = 1'b0;
    chk("rr_ack_count", 32'(n_ack), 32'd8);
    chk("rr_rw_count", 32'(n_rw), 32'd8);
    chk("rr_last_grant", 32'(bus.grant_id), 32'd3);
    tick();
    tick();

    // Single write then read by requester 2.
    do_txn(2, 1'b1, 8'h03, 8'h2A, lat, rw_trace, addr1);
    chk("wr_latency", 32'(lat), 32'd2);
    chk("wr_rw_trace", 32'(rw_trace), 32'h02);
    chk("wr_addr", 32'(addr1), 32'h03);
    do_txn(2, 1'b0, 8'h03, 8'h00, lat, rw_trace, addr1);
    chk("rd_latency", 32'(lat), 32'd3);
    chk("rd_rw_trace", 32'(rw_trace), 32'h00);
    chk("rd_addr", 32'(addr1), 32'h03);

    // Requester 1 holds req through its ack: masked one cycle, then regranted.
    hold_req = 1'b1;
    push_exp(1, 1'b1, 8'h20, 8'h55);
    push_exp(1, 1'b1, 8'h20, 8'h55);
    set_req(1, 1'b1, 8'h20, 8'h55);
    tick();
    chk("mask_rw1", 32'(bus.ram_r_w), 32'd1);
    tick();
    chk("mask_ack", 32'(bus.ack), 32'h2);
    tick();
    chk("mask_no_regrant_busy", 32'(bus.busy), 32'd0);
    chk("mask_no_regrant_rw", 32'(bus.ram_r_w), 32'd0);
    tick();
    chk("mask_regrant_rw", 32'(bus.ram_r_w), 32'd1);
    chk("mask_regrant_id", 32'(bus.grant_id), 32'd1);
    tick();
    chk("mask_ack2", 32'(bus.ack), 32'h2);
    bus.req = 4'h0;
    hold_req = 1'b0;
    tick();
    chk("mask_idle", 32'(bus.busy), 32'd0);

    // Reset while requester 3 is in RDWAIT.
    set_req(3, 1'b0, 8'h10, 8'h00);
    tick();
    chk("midrst_access_busy", 32'(bus.busy), 32'd1);
    tick();
    chk("midrst_rdwait_busy", 32'(bus.busy), 32'd1);
    reset = 1'b0;
    tick();
    chk("midrst_ack", 32'(bus.ack), 32'd0);
    chk("midrst_rdata", 32'(bus.rdata), 32'd0);
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    bus.req = 4'h0;
    tick();
    reset = 1'b1;
    tick();

    // Requesters 0 and 3 together after reset: 0 first.
    push_exp(0, 1'b1, 8'h30, 8'h11);
    push_exp(3, 1'b1, 8'h31, 8'h33);
    set_req(0, 1'b1, 8'h30, 8'h11);
    set_req(3, 1'b1, 8'h31, 8'h33);
    bound = 0;
    while (sb.size() != 0 && bound < 10) begin
      tick();
      bound++;
    end
    chk("prio_done", 32'(sb.size()), 32'd0);
    bus.req = 4'h0;
    tick();

    // Address change after grant is ignored.
    do_txn(0, 1'b1, 8'h01, 8'h77, lat, rw_trace, addr1);
    do_txn(0, 1'b1, 8'h02, 8'h99, lat, rw_trace, addr1);
    push_exp(0, 1'b0, 8'h01, 8'h00);
    set_req(0, 1'b0, 8'h01, 8'h00);
    tick();
    chk("latch_addr_access", 32'(bus.ram_addr), 32'h01);
    bus.addr[7:0] = 8'h02;
    tick();
    chk("latch_addr_rdwait", 32'(bus.ram_addr), 32'h01);
    tick();
    chk("latch_ack", 32'(bus.ack), 32'h1);
    chk("latch_rdata", 32'(bus.rdata), 32'h77);
    bus.req = 4'h0;
    tick();
    tick();

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
